// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI slave with a command byte + one data frame register protocol.
// All SPI pins are oversampled in the i_Clk domain; nothing is clocked by SCLK.
// Optional build macro SPI_REG_AUTO_INC_EN: back-to-back data frames at address+1
// while CS_n stays low (default build ignores extra frames).
module spi_reg_slave #(
    parameter int unsigned SPI_MODE   = 0,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic                           i_SPI_Clk,
    input  logic                           i_SPI_CS_n,
    input  logic                           i_SPI_MOSI,
    output logic                           o_SPI_MISO,
    input  logic [DATA_WIDTH-1:0]          i_Status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_Regs,
    output logic                           o_Wr_Stb,
    output logic [ADDR_WIDTH-1:0]          o_Wr_Addr,
    output logic                           o_Frame_Err
);

    localparam bit          CPOL      = ((SPI_MODE >> 1) & 1) != 0;
    localparam bit          CPHA      = (SPI_MODE & 1) != 0;
    localparam int unsigned CNT_W     = 6;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic cs_meta, cs_sync, cs_prev;
    logic mosi_meta, mosi_sync;

    logic [CNT_W-1:0]      bit_cnt;
    logic [6:0]            cmd_shift;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  rd_q;
    logic                  status_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  frame_done_q;
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

    logic                  sclk_rise_c, sclk_fall_c;
    logic                  sample_c, shift_c;
    logic                  cs_fall_c, cs_rise_c;
    logic                  cmd_done_c, frame_last_c, abort_c, commit_c;
    logic [7:0]            cmd_byte_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic                  ld_status_c;
    logic [ADDR_WIDTH-1:0] ld_addr_c;
    logic [DATA_WIDTH-1:0] ld_val_c;

    // Two-flop synchronisers on every pin plus history flops for edge detection
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sclk_meta <= CPOL;
            sclk_sync <= CPOL;
            sclk_prev <= CPOL;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= i_SPI_Clk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            cs_meta   <= i_SPI_CS_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= i_SPI_MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    // Map synced SCLK transitions onto sample/shift edges for the selected mode
    always_comb begin
        sclk_rise_c = sclk_sync & ~sclk_prev;
        sclk_fall_c = ~sclk_sync & sclk_prev;
        if (CPOL == CPHA) begin
            sample_c = sclk_rise_c;
            shift_c  = sclk_fall_c;
        end else begin
            sample_c = sclk_fall_c;
            shift_c  = sclk_rise_c;
        end
        cs_fall_c = ~cs_sync & cs_prev;
        cs_rise_c = cs_sync & ~cs_prev;
    end

    // FSM state register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and frame-level events
    always_comb begin
        state_next   = state;
        cmd_done_c   = 1'b0;
        frame_last_c = 1'b0;
        abort_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall_c) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cs_rise_c) begin
                    abort_c    = 1'b1;
                    state_next = ST_IDLE;
                end else if (sample_c && bit_cnt == CMD_LAST) begin
                    cmd_done_c = 1'b1;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cs_rise_c) begin
                    // A rise right after a completed burst frame is a clean end
                    abort_c    = !(frame_done_q && bit_cnt == '0);
                    state_next = ST_IDLE;
                end else if (sample_c && bit_cnt == DATA_LAST) begin
                    frame_last_c = 1'b1;
`ifdef SPI_REG_AUTO_INC_EN
                    state_next   = ST_DATA;
`else
                    state_next   = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                if (cs_rise_c) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command decode, write data assembly and read-value selection
    always_comb begin
        cmd_byte_c = {cmd_shift, mosi_sync};
        wr_data_c  = {rx_shift, mosi_sync};
        commit_c   = frame_last_c && !rd_q && (addr_q != '0) &&
                     (32'(addr_q) < NUM_REGS);
        if (state == ST_CMD) begin
            ld_status_c = (cmd_byte_c == 8'hFF);
            ld_addr_c   = cmd_byte_c[ADDR_WIDTH-1:0];
        end else begin
            ld_status_c = status_q;
            ld_addr_c   = addr_q + ADDR_WIDTH'(1);
        end
        ld_val_c = '0;
        if (ld_status_c || ld_addr_c == '0) begin
            ld_val_c = i_Status;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (ld_addr_c == ADDR_WIDTH'(i)) begin
                    ld_val_c = regs[i];
                end
            end
        end
    end

    // Shift registers, counters, MISO and pulse outputs
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            bit_cnt      <= '0;
            cmd_shift    <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            rd_q         <= 1'b0;
            status_q     <= 1'b0;
            addr_q       <= '0;
            frame_done_q <= 1'b0;
            o_SPI_MISO   <= 1'b0;
            o_Wr_Stb     <= 1'b0;
            o_Wr_Addr    <= '0;
            o_Frame_Err  <= 1'b0;
        end else begin
            o_Wr_Stb    <= 1'b0;
            o_Frame_Err <= abort_c;
            case (state)
                ST_IDLE: begin
                    bit_cnt      <= '0;
                    frame_done_q <= 1'b0;
                    o_SPI_MISO   <= 1'b0;
                end
                ST_CMD: begin
                    if (cs_rise_c) begin
                        o_SPI_MISO <= 1'b0;
                    end else if (sample_c) begin
                        cmd_shift <= cmd_byte_c[6:0];
                        if (cmd_done_c) begin
                            bit_cnt      <= '0;
                            rd_q         <= cmd_byte_c[7];
                            status_q     <= ld_status_c;
                            addr_q       <= ld_addr_c;
                            frame_done_q <= 1'b0;
                            if (cmd_byte_c[7] && !CPHA) begin
                                o_SPI_MISO <= ld_val_c[DATA_WIDTH-1];
                                tx_shift   <= {ld_val_c[DATA_WIDTH-2:0], 1'b0};
                            end else if (cmd_byte_c[7]) begin
                                tx_shift   <= ld_val_c;
                            end else begin
                                tx_shift   <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_rise_c) begin
                        o_SPI_MISO <= 1'b0;
                    end else if (sample_c) begin
                        rx_shift <= wr_data_c[DATA_WIDTH-2:0];
                        if (frame_last_c) begin
                            bit_cnt <= '0;
                            if (commit_c) begin
                                o_Wr_Stb  <= 1'b1;
                                o_Wr_Addr <= addr_q;
                            end
`ifdef SPI_REG_AUTO_INC_EN
                            addr_q       <= ld_addr_c;
                            frame_done_q <= 1'b1;
                            if (rd_q && !CPHA) begin
                                o_SPI_MISO <= ld_val_c[DATA_WIDTH-1];
                                tx_shift   <= {ld_val_c[DATA_WIDTH-2:0], 1'b0};
                            end else if (rd_q) begin
                                o_SPI_MISO <= 1'b0;
                                tx_shift   <= ld_val_c;
                            end else begin
                                o_SPI_MISO <= 1'b0;
                            end
`else
                            o_SPI_MISO <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (shift_c && rd_q && (CPHA || bit_cnt != '0)) begin
                        // CPHA=0 already presented the MSB at load; skip the trailing edge that follows it
                        o_SPI_MISO <= tx_shift[DATA_WIDTH-1];
                        tx_shift   <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    o_SPI_MISO <= 1'b0;
                end
                default: begin
                    o_SPI_MISO <= 1'b0;
                end
            endcase
        end
    end

    // Writable register bank; address 0 is status and never stored
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_c) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (addr_q == ADDR_WIDTH'(i)) begin
                    regs[i] <= wr_data_c;
                end
            end
        end
    end

    // Flatten the bank; slice 0 mirrors the live status word
    always_comb begin
        o_Regs = '0;
        o_Regs[DATA_WIDTH-1:0] = i_Status;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            o_Regs[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: dut0 runs SPI mode 0, dut1 runs mode 3, both with 8 registers.
`timescale 1ns/1ps
module tb_spi_reg_slave;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 4;
    localparam int unsigned NR   = 8;
    localparam int          HALF = 80;
    localparam int          BIT  = 2 * HALF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] status = 8'h02;
    logic          sclk [2] = '{1'b0, 1'b1};
    logic          cs_n [2] = '{1'b1, 1'b1};
    logic          mosi [2] = '{1'b0, 1'b0};

    logic             miso0, miso1;
    logic [NR*DW-1:0] regs0, regs1;
    logic             wr_stb0, wr_stb1;
    logic [AW-1:0]    wr_addr0, wr_addr1;
    logic             frame_err0, frame_err1;

    int stb_cnt [2] = '{0, 0};
    int err_cnt [2] = '{0, 0};
    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    spi_reg_slave #(.SPI_MODE(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_SPI_Clk(sclk[0]), .i_SPI_CS_n(cs_n[0]),
        .i_SPI_MOSI(mosi[0]), .o_SPI_MISO(miso0), .i_Status(status), .o_Regs(regs0),
        .o_Wr_Stb(wr_stb0), .o_Wr_Addr(wr_addr0), .o_Frame_Err(frame_err0)
    );

    spi_reg_slave #(.SPI_MODE(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_SPI_Clk(sclk[1]), .i_SPI_CS_n(cs_n[1]),
        .i_SPI_MOSI(mosi[1]), .o_SPI_MISO(miso1), .i_Status(status), .o_Regs(regs1),
        .o_Wr_Stb(wr_stb1), .o_Wr_Addr(wr_addr1), .o_Frame_Err(frame_err1)
    );

    // Count strobe and frame-error pulses per DUT
    always @(posedge clk) begin
        if (wr_stb0)    stb_cnt[0] <= stb_cnt[0] + 1;
        if (wr_stb1)    stb_cnt[1] <= stb_cnt[1] + 1;
        if (frame_err0) err_cnt[0] <= err_cnt[0] + 1;
        if (frame_err1) err_cnt[1] <= err_cnt[1] + 1;
    end

    function automatic logic get_miso(input int m);
        return (m == 0) ? miso0 : miso1;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // Master transfer: command byte then ndata data bits; rx collects MISO during data bits
    task automatic xfer(input int m, input logic [7:0] cmd, input logic [7:0] data,
                        input int ndata, output logic [7:0] rx);
        logic [15:0] frame;
        logic        cp;
        logic        b;
        cp    = (m == 1);
        frame = {cmd, data};
        rx    = '0;
        cs_n[m] = 1'b0;
        #HALF;
        for (int i = 0; i < 8 + ndata; i++) begin
            b = frame[15 - i];
            if (!cp) begin
                mosi[m] = b;
                #HALF;
                if (i >= 8) rx = {rx[6:0], get_miso(m)};
                sclk[m] = 1'b1;
                #HALF;
                sclk[m] = 1'b0;
            end else begin
                sclk[m] = 1'b0;
                mosi[m] = b;
                #HALF;
                if (i >= 8) rx = {rx[6:0], get_miso(m)};
                sclk[m] = 1'b1;
                #HALF;
            end
        end
        #HALF;
        cs_n[m] = 1'b1;
        mosi[m] = 1'b0;
        #200;
    endtask

    initial begin
        logic [7:0] rx;
        int         s;
        int         e;

        // Reset values
        rst = 1'b1;
        #100;
        check("rst_miso0", 64'(miso0), 64'h0);
        check("rst_miso1", 64'(miso1), 64'h0);
        check("rst_stb", 64'(wr_stb0), 64'h0);
        check("rst_addr", 64'(wr_addr0), 64'h0);
        check("rst_ferr", 64'(frame_err0), 64'h0);
        check("rst_regs", regs0, 64'h0000_0000_0000_0002);
        rst = 1'b0;
        #100;

        // Mode 0 write reg5 = A5
        s = stb_cnt[0];
        xfer(0, 8'h05, 8'hA5, 8, rx);
        check("m0_wr_stb_cnt", 64'(stb_cnt[0] - s), 64'd1);
        check("m0_wr_addr", 64'(wr_addr0), 64'd5);
        check("m0_wr_regs", regs0, 64'h0000_A500_0000_0002);

        // Mode 3 write then read back
        s = stb_cnt[1];
        xfer(1, 8'h05, 8'h3C, 8, rx);
        check("m3_wr_stb_cnt", 64'(stb_cnt[1] - s), 64'd1);
        check("m3_reg5", 64'(regs1[47:40]), 64'h3C);
        s = stb_cnt[1];
        xfer(1, 8'h85, 8'h00, 8, rx);
        check("m3_rd_data", 64'(rx), 64'h3C);
        check("m3_rd_no_stb", 64'(stb_cnt[1] - s), 64'd0);

        // Legacy status read, status changes mid-frame
        status = 8'h02;
        fork
            xfer(1, 8'hFF, 8'h00, 8, rx);
            begin
                #((8 + 3) * BIT + HALF);
                status = 8'h01;
            end
        join
        check("stat_held", 64'(rx), 64'h02);
        xfer(0, 8'hFF, 8'h00, 8, rx);
        check("stat_m0", 64'(rx), 64'h01);
        check("stat_mirror", 64'(regs0[7:0]), 64'h01);

        // Aborted write to reg3 after 4 data bits, then a full one
        s = stb_cnt[0];
        e = err_cnt[0];
        xfer(0, 8'h03, 8'h5A, 4, rx);
        check("abort_ferr", 64'(err_cnt[0] - e), 64'd1);
        check("abort_no_stb", 64'(stb_cnt[0] - s), 64'd0);
        check("abort_reg3", 64'(regs0[31:24]), 64'h00);
        xfer(0, 8'h03, 8'h5A, 8, rx);
        check("retry_stb", 64'(stb_cnt[0] - s), 64'd1);
        check("retry_ferr", 64'(err_cnt[0] - e), 64'd1);
        check("retry_reg3", 64'(regs0[31:24]), 64'h5A);

        // Address boundaries: 0 (status), 0x0F (unimplemented), 7 (last real)
        s = stb_cnt[0];
        e = err_cnt[0];
        xfer(0, 8'h00, 8'h77, 8, rx);
        check("a0_no_stb", 64'(stb_cnt[0] - s), 64'd0);
        check("a0_no_ferr", 64'(err_cnt[0] - e), 64'd0);
        xfer(0, 8'h80, 8'h00, 8, rx);
        check("a0_rd_status", 64'(rx), 64'h01);
        xfer(0, 8'h0F, 8'h99, 8, rx);
        check("aF_no_stb", 64'(stb_cnt[0] - s), 64'd0);
        xfer(0, 8'h8F, 8'h00, 8, rx);
        check("aF_rd_zero", 64'(rx), 64'h00);
        xfer(0, 8'h07, 8'h81, 8, rx);
        check("a7_stb", 64'(stb_cnt[0] - s), 64'd1);
        xfer(0, 8'h87, 8'h00, 8, rx);
        check("a7_rd", 64'(rx), 64'h81);
        check("bank_all", regs0, 64'h8100_A500_5A00_0001);
        check("miso_idle", 64'(miso0), 64'h0);

        // Reset in the middle of a write data frame
        s = stb_cnt[0];
        fork
            xfer(0, 8'h06, 8'hEE, 8, rx);
            begin
                #((8 + 4) * BIT);
                rst = 1'b1;
                #1;
                check("mrst_miso", 64'(miso0), 64'h0);
                check("mrst_stb", 64'(wr_stb0), 64'h0);
                check("mrst_addr", 64'(wr_addr0), 64'h0);
                check("mrst_regs", regs0, 64'h0000_0000_0000_0001);
            end
        join
        #50;
        rst = 1'b0;
        #100;
        check("mrst_no_commit", regs0, 64'h0000_0000_0000_0001);
        check("mrst_no_stb", 64'(stb_cnt[0] - s), 64'd0);

        // Normal operation after reset
        xfer(0, 8'h02, 8'hC3, 8, rx);
        check("post_regs", regs0, 64'h0000_0000_00C3_0001);
        check("post_addr", 64'(wr_addr0), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- Parametrised SPI slave with a command/register protocol. It replaces the fixed single-byte slave-plus-FSM pairing with a generic register bank.
- A master sends a command byte (R/W and address), then one DATA_WIDTH data frame. Write frames update a register. Read frames return a register, or the external status word driven by the local FSM.
- All SPI pins are oversampled in the system clock domain. There is no logic clocked by SCLK.

Parameters:
- SPI_MODE, 0, SPI mode 0-3 (CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]).
- DATA_WIDTH, 8, bits per data frame and per register (8..32).
- ADDR_WIDTH, 4, address bits taken from command byte bits [ADDR_WIDTH-1:0] (1..6).
- NUM_REGS, 16, implemented registers (2..2^ADDR_WIDTH). Address 0 is read-only status.

Ports:
- i_Clk  in  1  system clock; must be at least 8x the SCLK frequency.
- i_Rst  in  1  asynchronous, active-high reset.
- i_SPI_Clk  in  1  SCLK from master.
- i_SPI_CS_n  in  1  chip select, active low.
- i_SPI_MOSI  in  1  serial data in, MSB first.
- o_SPI_MISO  out  1  serial data out, MSB first.
- i_Status  in  DATA_WIDTH  external state word (e.g. FSM state), readable at address 0 and via command 0xFF.
- o_Regs  out  NUM_REGS*DATA_WIDTH  flattened register bank; reg n occupies [n*DATA_WIDTH +: DATA_WIDTH]; slice 0 mirrors i_Status.
- o_Wr_Stb  out  1  one-cycle pulse on register commit.
- o_Wr_Addr  out  ADDR_WIDTH  address of last commit.
- o_Frame_Err  out  1  one-cycle pulse when CS deasserts mid-frame.

Behaviour:
- Reset (async, i_Rst=1): writable registers = 0; o_SPI_MISO=0; o_Wr_Stb=0; o_Wr_Addr=0; o_Frame_Err=0; FSM=IDLE; bit counter=0; synchronisers cleared to idle levels (SCLK=CPOL, CS_n=1). Reset asserted mid-transfer aborts with no commit.
- Synchronisation: SCLK, CS_n and MOSI each pass through 2 flops. A third SCLK flop provides edge detection.
- Sample edge: leading edge for CPHA=0, trailing edge for CPHA=1. The opposite edge is the shift edge.
- Pin-to-action latency: 3 i_Clk cycles from pin edge.
- Command byte:
  - Bit 7 = 1 means read.
  - Bits [ADDR_WIDTH-1:0] are the address. Remaining bits are ignored.
  - Exception: cmd 0xFF is a legacy status read and returns i_Status regardless of decode.
- FSM states:
  - IDLE: wait for synced CS_n falling. Then go to CMD, clear bit counter, drive MISO=0.
  - CMD: shift in 8 bits on sample edges. On the 8th sample, latch the command. For a read, load the tx shift register with the addressed value within 1 cycle. Go to DATA.
  - DATA: sample DATA_WIDTH bits. Read: MISO updates on shift edges. CPHA=0 presents the MSB immediately after the load. Write: MOSI shifts into the rx register. On the last sample, a write with address in 1..NUM_REGS-1 commits: reg updated and o_Wr_Stb pulses in the same cycle, o_Wr_Addr updated. Then go to DONE.
  - DONE: further SCLK edges are ignored; MISO=0. Return to IDLE on CS_n rising.
- CS_n rising in CMD or DATA before the last sample: pulse o_Frame_Err, no commit, return to IDLE.
- CS_n rising in IDLE or DONE is not an error.
- Address boundaries:
  - Address 0 write is discarded; no strobe, no error.
  - Address >= NUM_REGS: reads return 0; writes are discarded with no strobe.
- i_Status is captured into the tx register at load time and held for the whole frame.
- MISO is 0 whenever CS_n is high or the FSM is not in a read DATA phase.

Optional Feature:
- Macro: SPI_REG_AUTO_INC_EN.
- Defined:
  - DONE is not used.
  - After a data frame, if CS stays low, another DATA frame follows at address+1, wrapping modulo 2^ADDR_WIDTH. Each frame commits or reloads independently.
  - A 0xFF burst re-reads i_Status every frame.
  - CS rising on a frame boundary is not an error; mid-frame rising still aborts that frame only.
- Undefined: behaviour exactly as above, with extra frames ignored in DONE.

Test Plan:
- Mode 0, write 0x05 then 0xA5 -> o_Wr_Stb one pulse, o_Wr_Addr=5, reg5=0xA5, other regs 0.
- Mode 3, write reg5=0x3C, then read 0x85 -> MISO returns 0x3C MSB first; no o_Wr_Stb on the read.
- i_Status=0x02, send cmd 0xFF -> MISO returns 0x02. Change i_Status mid-frame to 0x01 -> still returns 0x02.
- Write cmd 0x03, raise CS after 4 data bits -> o_Frame_Err pulses once, reg3 unchanged, next full transfer succeeds.
- Write to address 0 and to address 0x0F with NUM_REGS=8 -> no strobe, reads return i_Status and 0 respectively.
- Assert i_Rst mid-data-frame of a write -> all outputs at reset values immediately, no commit. With SPI_REG_AUTO_INC_EN, a write burst at 0x0E of 3 frames lands at 14, 15, 0 (0 discarded).
